// File: rtl/note_sprite_engine.sv
// note_sprite_engine
//   Game-state stage feeding the VGA sprite drawer. Holds one fixed target
//   sprite (slot 0) and five scrolling note slots (slots 1..5). Each frame
//   tick walks the notes left, resolves key presses against the hit window,
//   places a pending spawn, then publishes all drawer-facing outputs on a
//   single edge so the drawer never sees a half-updated frame.
//
// Ports
//   CLOCK_50      in   system clock, all logic on posedge
//   reset         in   synchronous, active-high
//   frame_tick    in   one-cycle pulse requesting one frame update
//   spawn_valid   in   request to add a note (accepted when spawn_ready)
//   spawn_colour  in   2-bit colour: 0=PINK 1=YELLOW 2=RED 3=BLUE
//   spawn_ready   out  high when no spawn is pending
//   key           in   key press pulses, bit index = colour code
//   sprite_types  out  slot k type at [5k+4:5k]
//   sprite_pos    out  slot k x at [17k+8:17k], y at [17k+16:17k+9]
//   score         out  saturating hit count
//   hit_pulse     out  one cycle per hit
//   miss_pulse    out  one cycle per missed note
//   spawn_drop    out  one cycle when a pending spawn finds every slot full
//   busy          out  high whenever the frame FSM is not idle
//
// Spawn handshake: a spawn transfers on a clock edge where spawn_valid and
// spawn_ready are both high; spawn_ready then stays low until the pending
// note has been placed or dropped in the next frame's SPAWN cycle.
module note_sprite_engine #(
    parameter int SPAWN_X  = 304,
    parameter int STEP     = 4,
    parameter int TARGET_X = 72,
    parameter int WINDOW   = 8
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          spawn_valid,
    input  logic [1:0]    spawn_colour,
    output logic          spawn_ready,
    input  logic [3:0]    key,
    output logic [29:0]   sprite_types,
    output logic [101:0]  sprite_pos,
    output logic [7:0]    score,
    output logic          hit_pulse,
    output logic          miss_pulse,
    output logic          spawn_drop,
    output logic          busy
);

    localparam logic [8:0] WIN_LO    = 9'(TARGET_X - WINDOW);
    localparam logic [8:0] WIN_HI    = 9'(TARGET_X + WINDOW);
    // A note below this x would leave the window on its next step.
    localparam logic [8:0] MISS_X    = 9'(TARGET_X - WINDOW + STEP);
    localparam logic [8:0] STEP_X    = 9'(STEP);
    localparam logic [8:0] SPAWN_POS = 9'(SPAWN_X);

    localparam logic [4:0] TYPE_NONE   = 5'b01100;
    localparam logic [4:0] TYPE_TARGET = 5'b00100;
    localparam logic [8:0] TARGET_XPOS = 9'd64;
    localparam logic [7:0] TARGET_Y    = 8'd104;
    localparam logic [7:0] NOTE_Y      = 8'd112;

    typedef enum logic [3:0] {
        IDLE,
        MOVE1,
        MOVE2,
        MOVE3,
        MOVE4,
        MOVE5,
        SPAWN,
        PUBLISH
    } state_t;

    state_t state;
    state_t next_state;

    // Note slots 1..5 live at internal index 0..4.
    logic [4:0] active;
    logic [1:0] colour [5];
    logic [8:0] xpos   [5];
    logic [7:0] score_r;

    logic       tick_pend;
    logic       spawn_pend;
    logic [1:0] spawn_pend_colour;
    logic [3:0] key_pend;
    logic [3:0] key_used;

    // FSM-derived per-cycle controls
    logic       in_move;
    logic [2:0] slot;

    logic       cur_active;
    logic [1:0] cur_colour;
    logic [8:0] cur_x;
    logic       do_hit;
    logic       do_miss;
    logic       do_move;

    logic       free_any;
    logic [2:0] free_idx;

    logic [29:0]  next_types;
    logic [101:0] next_pos;

    assign spawn_ready = ~spawn_pend;
    assign busy        = (state != IDLE);

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and current move slot
    always_comb begin
        next_state = state;
        in_move    = 1'b0;
        slot       = 3'd0;
        case (state)
            IDLE:    if (tick_pend) next_state = MOVE1;
            MOVE1:   begin in_move = 1'b1; slot = 3'd0; next_state = MOVE2; end
            MOVE2:   begin in_move = 1'b1; slot = 3'd1; next_state = MOVE3; end
            MOVE3:   begin in_move = 1'b1; slot = 3'd2; next_state = MOVE4; end
            MOVE4:   begin in_move = 1'b1; slot = 3'd3; next_state = MOVE5; end
            MOVE5:   begin in_move = 1'b1; slot = 3'd4; next_state = SPAWN; end
            SPAWN:   next_state = PUBLISH;
            PUBLISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Hit / miss / move decision for the slot being visited
    always_comb begin
        cur_active = 1'b0;
        cur_colour = 2'd0;
        cur_x      = 9'd0;
        for (int i = 0; i < 5; i++) begin
            if (slot == 3'(i)) begin
                cur_active = active[i];
                cur_colour = colour[i];
                cur_x      = xpos[i];
            end
        end
        do_hit  = in_move && cur_active
                  && key_pend[cur_colour] && !key_used[cur_colour]
                  && (cur_x >= WIN_LO) && (cur_x <= WIN_HI);
        do_miss = in_move && cur_active && !do_hit && (cur_x < MISS_X);
        do_move = in_move && cur_active && !do_hit && !do_miss;
    end

    // Lowest-index free slot for spawning
    always_comb begin
        free_any = 1'b0;
        free_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (!active[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    // Drawer-facing image of the current internal state
    always_comb begin
        next_types       = '0;
        next_pos         = '0;
        next_types[4:0]  = TYPE_TARGET;
        next_pos[16:0]   = {TARGET_Y, TARGET_XPOS};
        for (int i = 0; i < 5; i++) begin
            if (active[i]) begin
                next_types[5*(i+1) +: 5]  = {3'b000, colour[i]};
                next_pos[17*(i+1) +: 17]  = {NOTE_Y, xpos[i]};
            end else begin
                next_types[5*(i+1) +: 5]  = TYPE_NONE;
                next_pos[17*(i+1) +: 17]  = 17'd0;
            end
        end
    end

    // Datapath
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            active            <= '0;
            for (int i = 0; i < 5; i++) begin
                colour[i] <= 2'd0;
                xpos[i]   <= 9'd0;
            end
            score_r           <= 8'd0;
            tick_pend         <= 1'b0;
            spawn_pend        <= 1'b0;
            spawn_pend_colour <= 2'd0;
            key_pend          <= 4'd0;
            key_used          <= 4'd0;
            hit_pulse         <= 1'b0;
            miss_pulse        <= 1'b0;
            spawn_drop        <= 1'b0;
            sprite_types      <= {{5{TYPE_NONE}}, TYPE_TARGET};
            sprite_pos        <= {85'd0, TARGET_Y, TARGET_XPOS};
            score             <= 8'd0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            spawn_drop <= 1'b0;

            // IDLE consumes the pending tick; ticks arriving while one is
            // already pending merge into it.
            if (state == IDLE) tick_pend <= frame_tick;
            else               tick_pend <= tick_pend | frame_tick;

            // Keys stay latched for the whole frame; a press landing in the
            // SPAWN cycle carries into the next frame.
            if (state == SPAWN) begin
                key_pend <= key;
                key_used <= 4'd0;
            end else begin
                key_pend <= key_pend | key;
                if (do_hit) key_used[cur_colour] <= 1'b1;
            end

            if (do_hit) begin
                active[slot] <= 1'b0;
                hit_pulse    <= 1'b1;
                if (score_r != 8'hFF) score_r <= score_r + 8'd1;
            end
            if (do_miss) begin
                active[slot] <= 1'b0;
                miss_pulse   <= 1'b1;
            end
            if (do_move) xpos[slot] <= cur_x - STEP_X;

            if (state == SPAWN && spawn_pend) begin
                if (free_any) begin
                    active[free_idx] <= 1'b1;
                    colour[free_idx] <= spawn_pend_colour;
                    xpos[free_idx]   <= SPAWN_POS;
                end else begin
                    spawn_drop <= 1'b1;
                end
                spawn_pend <= 1'b0;
            end else if (spawn_valid && !spawn_pend) begin
                spawn_pend        <= 1'b1;
                spawn_pend_colour <= spawn_colour;
            end

            if (state == PUBLISH) begin
                sprite_types <= next_types;
                sprite_pos   <= next_pos;
                score        <= score_r;
            end
        end
    end

endmodule
